icache_tag_ctrl: RTL and testbench
==================================

Name: icache_tag_ctrl

Overview:
Sequencing controller for the 4-way instruction-cache tag array. It accepts lookup requests from the fetch stage and reads all ways in parallel. It compares the tags, reports hit or miss, and on a miss issues a refill request. After the refill it writes the new tag into a victim way chosen by invalid-first / round-robin. It also serialises cache flushes against in-flight lookups.

Parameters:
N_WAY, 4, number of ways (power of 2)
TAG_WIDTH, 20, tag bits per way
ADDR_WIDTH, 8, set index bits (depth 256)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; asynchronous, active-low
lookup_valid_i  in  1  lookup request valid
lookup_ready_o  out  1  controller can accept a lookup
lookup_tag_i  in  TAG_WIDTH  physical tag of the request
lookup_idx_i  in  ADDR_WIDTH  set index of the request
flush_i  in  1  flush request (one-cycle pulse)
resp_valid_o  out  1  one-cycle response pulse
resp_hit_o  out  1  1 = hit, 0 = miss that was refilled
resp_way_o  out  log2(N_WAY)  way that hit or was filled
refill_req_o  out  1  refill request to lower level
refill_tag_o  out  TAG_WIDTH  refill tag
refill_idx_o  out  ADDR_WIDTH  refill index
refill_done_i  in  1  refill line written; tag may be committed
tag_req_o  out  N_WAY  per-way enable to tag array
tag_we_o  out  1  tag write enable
tag_vbit_o  out  1  valid bit written
tag_flush_o  out  1  clears all valid bits in tag array
tag_data_o  out  TAG_WIDTH  tag written
tag_addr_o  out  ADDR_WIDTH  set index to tag array
tag_way_i  in  N_WAY*TAG_WIDTH  read tags; way w at [w*TAG_WIDTH +: TAG_WIDTH]
vbit_i  in  N_WAY  read valid bits

Behaviour:
- Tag array read latency: 1 cycle (data valid the cycle after tag_req_o with tag_we_o = 0).
- Reset values:
  - state IDLE, round-robin pointer rr = 0, flush_pend = 0
  - tag_req_o = 0, tag_we_o = 0, tag_flush_o = 0
  - refill_req_o = 0, resp_valid_o = 0, resp_hit_o = 0, resp_way_o = 0
  - lookup_ready_o = 1
- FSM states: IDLE, LOOKUP, MISS, WRITE, FLUSH.
- IDLE:
  - lookup_ready_o = 1 unless (flush_i | flush_pend).
  - If flush_i or flush_pend: go to FLUSH; the lookup is not accepted that cycle.
  - Else, on handshake in cycle N: latch tag/idx, tag_req_o = all ones, tag_addr_o = idx, go to LOOKUP.
- LOOKUP (cycle N+1):
  - hit[w] = vbit_i[w] & (tag_way_i[w] == latched tag).
  - Any hit: lowest-index hitting way wins; registered resp_valid_o = 1, resp_hit_o = 1, resp_way_o = way at N+2; go to IDLE (new lookup may be accepted at N+2).
  - No hit: victim = lowest-index way with vbit_i = 0; if all ways are valid, victim = rr and rr increments mod N_WAY. Go to MISS.
- MISS:
  - refill_req_o = 1 with refill_tag_o / refill_idx_o = latched values, held stable until refill_done_i is sampled high (cycle M).
  - Go to WRITE at M+1.
- WRITE (M+1):
  - tag_req_o = onehot(victim), tag_we_o = 1, tag_vbit_o = 1, tag_data_o = latched tag, tag_addr_o = latched idx.
  - At M+2: resp_valid_o = 1, resp_hit_o = 0, resp_way_o = victim; go to IDLE.
- FLUSH:
  - tag_flush_o = 1 for exactly one cycle; clear flush_pend; go to IDLE.
  - rr is not reset by flush.
- flush_i while not in IDLE: set flush_pend. An in-flight miss completes its refill and tag write, then the flush executes before the next lookup. Multiple flush pulses collapse into one.
- tag_req_o is 0 in MISS and FLUSH; tag_we_o is high only in WRITE.
- refill_done_i outside MISS is ignored.
- Asynchronous reset mid-operation: all state returns to reset values immediately; a pending refill request is dropped.

Test Plan:
- Cold miss:
  - Stimulus: reset, lookup tag 0x12345 idx 0x10, vbit_i = 0000; refill_done_i 3 cycles later.
  - Required: refill_req_o high until done; WRITE with tag_req_o = 0001, tag_data_o = 0x12345; resp hit = 0, way = 0.
- Hit:
  - Stimulus: vbit_i = 1111, way 2 tag = 0x12345, lookup 0x12345.
  - Required: resp_valid_o at N+2 with hit = 1, way = 2; tag_we_o never asserted.
- Round-robin victim:
  - Stimulus: four successive misses with vbit_i = 1111.
  - Required: victims 0, 1, 2, 3, then 0 on the fifth miss.
- Invalid-first victim:
  - Stimulus: vbit_i = 1011, miss.
  - Required: victim = 2; rr unchanged.
- Flush during miss:
  - Stimulus: flush_i pulse while in MISS.
  - Required: the write completes, then a single tag_flush_o pulse; lookup_ready_o = 0 until after the flush.
- Async reset in MISS:
  - Stimulus: drop rstn_i while in MISS.
  - Required: refill_req_o = 0 immediately; lookup_ready_o = 1 after reset release.

Source files
------------

// File: rtl/icache_tag_ctrl.sv
// icache_tag_ctrl
// Sequencing controller for an N_WAY-way instruction-cache tag array.
// A lookup reads every way at once; the tags are compared the next cycle.
// A hit responds right away. A miss requests a refill from the lower level.
// Once the refill is done, the new tag is written into a victim way. The
// victim is the lowest invalid way, or the round-robin way when all ways are
// valid. Flushes that arrive during a lookup or miss are held until the
// current operation finishes. Pulses that arrive meanwhile merge into one.
//
// Ports
//   clk_i, rstn_i           clock, asynchronous active-low reset
//   lookup_valid_i/ready_o  lookup handshake; lookup_tag_i/lookup_idx_i payload
//   flush_i                 one-cycle flush request
//   resp_valid_o/hit_o/way_o  one-cycle response (hit, or miss that was filled)
//   refill_req_o/tag_o/idx_o  refill request, held until refill_done_i
//   refill_done_i           refill line written, tag may be committed
//   tag_req_o/we_o/vbit_o/flush_o/data_o/addr_o  tag array control
//   tag_way_i, vbit_i       tag array read data (one cycle after tag_req_o)
module icache_tag_ctrl #(
   parameter int N_WAY      = 4,
   parameter int TAG_WIDTH  = 20,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       lookup_valid_i,
   output logic                       lookup_ready_o,
   input  logic [TAG_WIDTH-1:0]       lookup_tag_i,
   input  logic [ADDR_WIDTH-1:0]      lookup_idx_i,
   input  logic                       flush_i,
   output logic                       resp_valid_o,
   output logic                       resp_hit_o,
   output logic [$clog2(N_WAY)-1:0]   resp_way_o,
   output logic                       refill_req_o,
   output logic [TAG_WIDTH-1:0]       refill_tag_o,
   output logic [ADDR_WIDTH-1:0]      refill_idx_o,
   input  logic                       refill_done_i,
   output logic [N_WAY-1:0]           tag_req_o,
   output logic                       tag_we_o,
   output logic                       tag_vbit_o,
   output logic                       tag_flush_o,
   output logic [TAG_WIDTH-1:0]       tag_data_o,
   output logic [ADDR_WIDTH-1:0]      tag_addr_o,
   input  logic [N_WAY*TAG_WIDTH-1:0] tag_way_i,
   input  logic [N_WAY-1:0]           vbit_i
);

   localparam int WAY_W = $clog2(N_WAY);

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_WRITE, S_FLUSH} state_e;

   state_e                  state_q, state_d;
   logic [TAG_WIDTH-1:0]    tag_q, tag_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [WAY_W-1:0]        victim_q, victim_d;
   logic [WAY_W-1:0]        rr_q, rr_d;
   logic                    flush_pend_q, flush_pend_d;
   logic                    resp_valid_q, resp_valid_d;
   logic                    resp_hit_q, resp_hit_d;
   logic [WAY_W-1:0]        resp_way_q, resp_way_d;

   logic [N_WAY-1:0]        hit;
   logic [WAY_W-1:0]        hit_way;
   logic [WAY_W-1:0]        inv_way;

   // Per-way tag compare against the latched request tag.
   genvar gi;
   generate
      for (gi = 0; gi < N_WAY; gi++) begin : g_cmp
         assign hit[gi] = vbit_i[gi] & (tag_way_i[gi*TAG_WIDTH +: TAG_WIDTH] == tag_q);
      end
   endgenerate

   // Lowest-index priority encoders. Scan from the top so that the lowest
   // matching index is the last one assigned.
   always_comb begin
      hit_way = '0;
      inv_way = '0;
      for (int w = N_WAY - 1; w >= 0; w--) begin
         if (hit[w])     hit_way = WAY_W'(w);
         if (!vbit_i[w]) inv_way = WAY_W'(w);
      end
   end

   always_comb begin
      state_d        = state_q;
      tag_d          = tag_q;
      idx_d          = idx_q;
      victim_d       = victim_q;
      rr_d           = rr_q;
      flush_pend_d   = flush_pend_q;
      resp_valid_d   = 1'b0;
      resp_hit_d     = resp_hit_q;
      resp_way_d     = resp_way_q;
      lookup_ready_o = 1'b0;
      tag_req_o      = '0;
      tag_we_o       = 1'b0;
      tag_vbit_o     = 1'b0;
      tag_flush_o    = 1'b0;
      refill_req_o   = 1'b0;
      tag_addr_o     = idx_q;

      // A flush that arrives mid-operation is remembered. While a flush is
      // already executing, another pulse adds nothing.
      if (flush_i && (state_q != S_IDLE) && (state_q != S_FLUSH))
         flush_pend_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            tag_addr_o = lookup_idx_i;
            if (flush_i || flush_pend_q) begin
               state_d = S_FLUSH;
            end else begin
               lookup_ready_o = 1'b1;
               if (lookup_valid_i) begin
                  tag_d     = lookup_tag_i;
                  idx_d     = lookup_idx_i;
                  tag_req_o = '1;
                  state_d   = S_LOOKUP;
               end
            end
         end
         S_LOOKUP: begin
            if (|hit) begin
               resp_valid_d = 1'b1;
               resp_hit_d   = 1'b1;
               resp_way_d   = hit_way;
               state_d      = S_IDLE;
            end else begin
               // The round-robin pointer only advances when it picks the
               // victim, so invalid-first fills leave it unchanged.
               if (&vbit_i) begin
                  victim_d = rr_q;
                  rr_d     = rr_q + 1'b1;
               end else begin
                  victim_d = inv_way;
               end
               state_d = S_MISS;
            end
         end
         S_MISS: begin
            refill_req_o = 1'b1;
            if (refill_done_i) state_d = S_WRITE;
         end
         S_WRITE: begin
            tag_req_o[victim_q] = 1'b1;
            tag_we_o            = 1'b1;
            tag_vbit_o          = 1'b1;
            resp_valid_d        = 1'b1;
            resp_hit_d          = 1'b0;
            resp_way_d          = victim_q;
            state_d             = S_IDLE;
         end
         S_FLUSH: begin
            tag_flush_o  = 1'b1;
            flush_pend_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= S_IDLE;
         tag_q        <= '0;
         idx_q        <= '0;
         victim_q     <= '0;
         rr_q         <= '0;
         flush_pend_q <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_way_q   <= '0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         idx_q        <= idx_d;
         victim_q     <= victim_d;
         rr_q         <= rr_d;
         flush_pend_q <= flush_pend_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         resp_way_q   <= resp_way_d;
      end
   end

   assign resp_valid_o = resp_valid_q;
   assign resp_hit_o   = resp_hit_q;
   assign resp_way_o   = resp_way_q;
   assign refill_tag_o = tag_q;
   assign refill_idx_o = idx_q;
   assign tag_data_o   = tag_q;

endmodule

// File: tb/tb_icache_tag_ctrl.sv
module tb_icache_tag_ctrl;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        lookup_valid_i;
   logic        lookup_ready_o;
   logic [19:0] lookup_tag_i;
   logic [7:0]  lookup_idx_i;
   logic        flush_i;
   logic        resp_valid_o;
   logic        resp_hit_o;
   logic [1:0]  resp_way_o;
   logic        refill_req_o;
   logic [19:0] refill_tag_o;
   logic [7:0]  refill_idx_o;
   logic        refill_done_i;
   logic [3:0]  tag_req_o;
   logic        tag_we_o;
   logic        tag_vbit_o;
   logic        tag_flush_o;
   logic [19:0] tag_data_o;
   logic [7:0]  tag_addr_o;
   logic [79:0] tag_way_i;
   logic [3:0]  vbit_i;

   int checks = 0;
   int passes = 0;

   icache_tag_ctrl #(.N_WAY(4), .TAG_WIDTH(20), .ADDR_WIDTH(8)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
      .lookup_tag_i(lookup_tag_i), .lookup_idx_i(lookup_idx_i),
      .flush_i(flush_i),
      .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_way_o(resp_way_o),
      .refill_req_o(refill_req_o), .refill_tag_o(refill_tag_o), .refill_idx_o(refill_idx_o),
      .refill_done_i(refill_done_i),
      .tag_req_o(tag_req_o), .tag_we_o(tag_we_o), .tag_vbit_o(tag_vbit_o),
      .tag_flush_o(tag_flush_o), .tag_data_o(tag_data_o), .tag_addr_o(tag_addr_o),
      .tag_way_i(tag_way_i), .vbit_i(vbit_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Full miss: issue in IDLE, refill_done after 'delay' MISS cycles, check the
   // write and the miss response.
   task automatic miss_seq(input string name, input logic [19:0] tag, input logic [7:0] idx,
                           input logic [3:0] vb, input logic [79:0] ways,
                           input logic [1:0] exp_way, input int delay);
      logic [3:0] onehot;
      onehot = 4'b0001 << exp_way;
      lookup_valid_i = 1'b1; lookup_tag_i = tag; lookup_idx_i = idx;
      vbit_i = vb; tag_way_i = ways;
      #1;
      chk({name, " lookup tag_req"}, 32'(tag_req_o), 32'hF);
      tick();                                   // LOOKUP
      lookup_valid_i = 1'b0;
      tick();                                   // MISS
      chk({name, " refill_req"}, 32'(refill_req_o), 32'h1);
      chk({name, " refill_tag"}, 32'(refill_tag_o), 32'(tag));
      for (int i = 1; i < delay; i++) tick();
      chk({name, " refill_req held"}, 32'(refill_req_o), 32'h1);
      refill_done_i = 1'b1;
      tick();                                   // WRITE
      refill_done_i = 1'b0;
      chk({name, " write tag_req"}, 32'(tag_req_o), 32'(onehot));
      chk({name, " write we"}, 32'(tag_we_o), 32'h1);
      tick();                                   // response
      chk({name, " resp"}, {29'd0, resp_valid_o, resp_hit_o, 1'b0} | 32'(resp_way_o), {29'd0, 1'b1, 1'b0, 1'b0} | 32'(exp_way));
      $display("miss %s: victim %0d way %0d", name, exp_way, resp_way_o);
   endtask

   localparam logic [79:0] ALL_A = {4{20'hAAAAA}};

   initial begin
      rstn_i = 1'b0; lookup_valid_i = 1'b0; lookup_tag_i = '0; lookup_idx_i = '0;
      flush_i = 1'b0; refill_done_i = 1'b0; tag_way_i = '0; vbit_i = '0;
      tick(); tick();
      chk("reset ready", 32'(lookup_ready_o), 32'h1);
      chk("reset refill_req", 32'(refill_req_o), 32'h0);
      chk("reset resp_valid", 32'(resp_valid_o), 32'h0);
      chk("reset tag ctl", {28'd0, tag_req_o} | 32'({tag_we_o, tag_flush_o} << 4), 32'h0);
      rstn_i = 1'b1;
      tick();

      // Cold miss: tag 0x12345 idx 0x10, all invalid, done 3 cycles into MISS.
      miss_seq("cold", 20'h12345, 8'h10, 4'b0000, '0, 2'd0, 3);
      chk("cold data", 32'(tag_data_o), 32'h12345);
      chk("cold addr", 32'(tag_addr_o), 32'h10);
      tick();
      chk("cold resp pulse", 32'(resp_valid_o), 32'h0);

      // Hit: ways 2 and 3 match, lowest wins.
      lookup_valid_i = 1'b1; lookup_tag_i = 20'h12345; lookup_idx_i = 8'h10;
      vbit_i = 4'b1111; tag_way_i = {20'h12345, 20'h12345, 20'h11111, 20'h22222};
      tick();
      lookup_valid_i = 1'b0;
      chk("hit lookup we", 32'(tag_we_o), 32'h0);
      chk("hit lookup ready", 32'(lookup_ready_o), 32'h0);
      tick();
      chk("hit resp_valid", 32'(resp_valid_o), 32'h1);
      chk("hit resp_hit", 32'(resp_hit_o), 32'h1);
      chk("hit resp_way", 32'(resp_way_o), 32'h2);
      chk("hit we", 32'(tag_we_o), 32'h0);
      chk("hit ready N+2", 32'(lookup_ready_o), 32'h1);
      $display("hit: way %0d", resp_way_o);

      // Round-robin: five full-set misses, victims 0,1,2,3,0.
      miss_seq("rr0", 20'h55555, 8'h20, 4'b1111, ALL_A, 2'd0, 1);
      miss_seq("rr1", 20'h55555, 8'h21, 4'b1111, ALL_A, 2'd1, 2);
      miss_seq("rr2", 20'h55555, 8'h22, 4'b1111, ALL_A, 2'd2, 1);
      miss_seq("rr3", 20'h55555, 8'h23, 4'b1111, ALL_A, 2'd3, 1);
      miss_seq("rr4", 20'h55555, 8'h24, 4'b1111, ALL_A, 2'd0, 1);

      // Invalid-first: way 2 invalid; rr stays at 1.
      miss_seq("inv", 20'h55555, 8'h30, 4'b1011, ALL_A, 2'd2, 1);

      // Flush during miss (two pulses, one flush). rr=1 -> victim 1.
      lookup_valid_i = 1'b1; lookup_tag_i = 20'h55555; lookup_idx_i = 8'h40;
      vbit_i = 4'b1111; tag_way_i = ALL_A;
      tick();                                   // LOOKUP
      lookup_valid_i = 1'b0;
      tick();                                   // MISS
      flush_i = 1'b1;
      #1;
      chk("flush miss ready", 32'(lookup_ready_o), 32'h0);
      tick();
      flush_i = 1'b0;
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0; refill_done_i = 1'b1;
      tick();                                   // WRITE
      refill_done_i = 1'b0;
      chk("flush write tag_req", 32'(tag_req_o), 32'h2);
      chk("flush write no flush", 32'(tag_flush_o), 32'h0);
      tick();                                   // IDLE with pending flush
      lookup_valid_i = 1'b1; lookup_idx_i = 8'h41;
      #1;
      chk("flush resp way", {31'd0, resp_valid_o} | 32'(resp_way_o << 1), 32'h3);
      chk("flush pend ready", 32'(lookup_ready_o), 32'h0);
      chk("flush pend tag_req", 32'(tag_req_o), 32'h0);
      tick();                                   // FLUSH
      lookup_valid_i = 1'b0;
      chk("flush pulse", 32'(tag_flush_o), 32'h1);
      chk("flush ready", 32'(lookup_ready_o), 32'h0);
      tick();
      chk("flush done", 32'(tag_flush_o), 32'h0);
      chk("flush ready after", 32'(lookup_ready_o), 32'h1);
      tick();
      chk("flush single", 32'(tag_flush_o), 32'h0);
      $display("flush during miss: done");

      // Async reset in MISS (rr advances to 3 in LOOKUP, reset returns it to 0).
      lookup_valid_i = 1'b1; lookup_tag_i = 20'h55555; lookup_idx_i = 8'h50;
      tick();
      lookup_valid_i = 1'b0;
      tick();                                   // MISS
      chk("areset pre refill_req", 32'(refill_req_o), 32'h1);
      #2 rstn_i = 1'b0;
      #1;
      chk("areset refill_req", 32'(refill_req_o), 32'h0);
      tick();
      rstn_i = 1'b1;
      #1;
      chk("areset ready", 32'(lookup_ready_o), 32'h1);
      miss_seq("post", 20'h55555, 8'h51, 4'b1111, ALL_A, 2'd0, 1);

      tick();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
